legv8_mc_ctrl: RTL and testbench
================================

# legv8_mc_ctrl

Multi-cycle main controller for the LEGv8 core. It decodes the 11-bit opcode field and sequences every instruction through FETCH, DECODE, EXEC, MEM and WB states, driving the datapath control strobes in each state. It sits between the instruction/data memory handshakes and the datapath, and replaces single-cycle combinational decoding. Compared with single-cycle decode it adds:

- unconditional B,
- a memory wait/timeout handshake,
- illegal-opcode reporting,
- a retired-instruction counter.

## Interface
Parameters:
- MEM_WAIT_MAX, 8: maximum cycles spent in MEM waiting for mem_ready; must be ≥1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  11  instr[31:21]; sampled only on the FETCH handshake.
- instr_valid  in  1  instruction word valid from instruction memory.
- instr_ready  out  1  controller accepts an instruction (FETCH only).
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  data memory completes the current access.
- ir_write  out  1  load IR; equals instr_valid & instr_ready.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- Reg2Loc  out  1  register-file read-address-2 select.
- ALUSrc  out  1  ALU operand B select.
- MemtoReg  out  1  writeback source select.
- RegWrite  out  1  register-file write strobe.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- ALUOp  out  2  ALU control class.
- illegal  out  1  one-cycle pulse on an unrecognised opcode.
- mem_timeout  out  1  one-cycle pulse on a memory timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Opcode classes:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (class R)
  - ADDI 1001000100x
  - CBZ 10110100xxx
  - CBNZ 10110101xxx
  - B 000101xxxxx
  - anything else: ILL
- Class register: loaded on the FETCH handshake and held until the next handshake.
- Mux selects (Reg2Loc, ALUSrc, MemtoReg, ALUOp) are driven from the class in DECODE through WB, and are 0 in FETCH:
  - LDUR: Reg2Loc=0, ALUSrc=1, MemtoReg=1, ALUOp=00.
  - STUR: Reg2Loc=1, ALUSrc=1, MemtoReg=0, ALUOp=00.
  - R: Reg2Loc=0, ALUSrc=0, MemtoReg=0, ALUOp=10.
  - ADDI: Reg2Loc=0, ALUSrc=1, MemtoReg=0, ALUOp=10.
  - CBZ/CBNZ: Reg2Loc=1, ALUSrc=0, MemtoReg=0, ALUOp=01.
  - B: Reg2Loc=0, ALUSrc=0, MemtoReg=0, ALUOp=00.
- Strobes are asserted only in their own state.
- FETCH:
  - instr_ready=1.
  - On instr_valid: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - ILL: illegal=1, next state FETCH, no other strobe.
  - Otherwise next state EXEC.
- EXEC:
  - CBZ: taken = zero. CBNZ: taken = !zero. B: taken = 1.
  - For CBZ/CBNZ/B: pc_write=taken, pc_src=1, retire, next state FETCH.
  - R/ADDI: next state WB.
  - LDUR/STUR: next state MEM, wait counter cleared.
- MEM:
  - MemRead=1 (LDUR) or MemWrite=1 (STUR), held every cycle until exit.
  - If mem_ready: LDUR next state WB; STUR retires, next state FETCH.
  - Else if counter == MEM_WAIT_MAX-1: mem_timeout=1, no retire, next state FETCH.
  - Else counter increments.
- WB: RegWrite=1, retire, next state FETCH.
- Retire: retired increments by 1 and wraps modulo 2^CNT_W. Illegal and timed-out instructions do not count.
- mem_ready outside MEM is ignored. zero outside EXEC is ignored.

## Timing
- Reset:
  - While reset=0: state=FETCH, class=ILL, counter=0, retired=0, and every output is forced to 0, including instr_ready.
  - First cycle after release: instr_ready=1.
  - Reset asserted mid-instruction aborts it immediately: no strobe may glitch high, and no retire occurs.
- Latency with instr_valid held high and mem_ready=1 on the first MEM cycle:
  - branch: 3 cycles
  - R/ADDI: 4 cycles
  - STUR: 4 cycles
  - LDUR: 5 cycles
  - ILL: 2 cycles
- MEM adds k cycles when mem_ready arrives k cycles late. Maximum residency in MEM is MEM_WAIT_MAX cycles.
- All outputs are combinational from registered state/class, except ir_write, which also depends on instr_valid.
- mem_ready arriving on the timeout cycle counts as success: no timeout pulse.

## Test plan
- ADD (10001011000) then ADDI (10010001000), instr_valid=1 → RegWrite high on cycles 4 and 8 only, ALUOp=10 in both, retired=2.
- LDUR with mem_ready delayed 3 cycles, MEM_WAIT_MAX=8 → MemRead high for 4 cycles, then WB with MemtoReg=1 and RegWrite=1; instruction takes 8 cycles.
- CBZ with zero=1, then CBNZ with zero=1 → first: pc_write=1, pc_src=1 in EXEC; second: pc_write=0 in EXEC; retired=2.
- STUR with mem_ready never asserted, MEM_WAIT_MAX=4 → MemWrite high for exactly 4 cycles, mem_timeout pulses once, back in FETCH, retired unchanged.
- Opcode 00000000000 → illegal pulses in DECODE, no RegWrite/MemWrite, FETCH on the next cycle.
- reset=0 asserted during LDUR's MEM state → MemRead drops immediately, retired=0, instr_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle LEGv8 main controller: classifies the opcode on fetch and walks
// FETCH/DECODE/EXEC/MEM/WB, driving datapath strobes and counting retired instructions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | waiting for instr_valid; handshake loads IR, class, PC+4
// S_DECODE | class known; illegal opcodes are reported and dropped here
// S_EXEC   | ALU step; branches resolve and retire here
// S_MEM    | data memory access, bounded by MEM_WAIT_MAX cycles
// S_WB     | register-file write, retire
module legv8_mc_ctrl #(
    parameter int MEM_WAIT_MAX = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ILL, C_LDUR, C_STUR, C_R, C_ADDI, C_CBZ, C_CBNZ, C_B} class_t;

    state_t            state, state_nxt;
    class_t            cls, dec_cls;
    logic [WAIT_W-1:0] wait_cnt, cnt_nxt;
    logic              retire, taken;
    logic              pw_c, ps_c, rw_c, mr_c, mw_c, ill_c, to_c;
    logic              r2l_c, as_c, m2r_c;
    logic [1:0]        aluop_c;

    always_comb begin
        casez (op)
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = C_R;
            11'b1001000100?: dec_cls = C_ADDI;
            11'b10110100???: dec_cls = C_CBZ;
            11'b10110101???: dec_cls = C_CBNZ;
            11'b000101?????: dec_cls = C_B;
            default:         dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            cls      <= C_ILL;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (state == S_FETCH && instr_valid)
                cls <= dec_cls;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    assign taken = (cls == C_B) || (cls == C_CBZ && zero) || (cls == C_CBNZ && !zero);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        retire    = 1'b0;
        pw_c      = 1'b0;
        ps_c      = 1'b0;
        rw_c      = 1'b0;
        mr_c      = 1'b0;
        mw_c      = 1'b0;
        ill_c     = 1'b0;
        to_c      = 1'b0;
        case (state)
            S_FETCH: begin
                if (instr_valid) begin
                    pw_c      = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls == C_ILL) begin
                    ill_c     = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_CBZ, C_CBNZ, C_B: begin
                        pw_c      = taken;
                        ps_c      = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    C_LDUR, C_STUR: begin
                        cnt_nxt   = '0;
                        state_nxt = S_MEM;
                    end
                    C_R, C_ADDI: state_nxt = S_WB;
                    default:     state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                mr_c = (cls == C_LDUR);
                mw_c = (cls == C_STUR);
                // A late mem_ready on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    if (cls == C_LDUR) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    to_c      = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                rw_c      = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        r2l_c   = 1'b0;
        as_c    = 1'b0;
        m2r_c   = 1'b0;
        aluop_c = 2'b00;
        if (state != S_FETCH) begin
            case (cls)
                C_LDUR: begin as_c = 1'b1; m2r_c = 1'b1; end
                C_STUR: begin r2l_c = 1'b1; as_c = 1'b1; end
                C_R:    aluop_c = 2'b10;
                C_ADDI: begin as_c = 1'b1; aluop_c = 2'b10; end
                C_CBZ, C_CBNZ: begin r2l_c = 1'b1; aluop_c = 2'b01; end
                default: ;
            endcase
        end
    end

    // State is already FETCH during reset, so every output is gated to stay quiet.
    assign instr_ready = reset && (state == S_FETCH);
    assign ir_write    = instr_valid && instr_ready;
    assign pc_write    = reset && pw_c;
    assign pc_src      = reset && ps_c;
    assign Reg2Loc     = reset && r2l_c;
    assign ALUSrc      = reset && as_c;
    assign MemtoReg    = reset && m2r_c;
    assign RegWrite    = reset && rw_c;
    assign MemRead     = reset && mr_c;
    assign MemWrite    = reset && mw_c;
    assign ALUOp       = reset ? aluop_c : 2'b00;
    assign illegal     = reset && ill_c;
    assign mem_timeout = reset && to_c;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Directed bench for legv8_mc_ctrl: per-cycle vector table plus hand-written
// sequences for memory wait, timeout (two MEM_WAIT_MAX values) and mid-instruction reset.
module tb_legv8_mc_ctrl;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_NEAR = 11'b11111000001;
    localparam logic [10:0] OP_ZERO = 11'b00000000000;

    // {instr_ready, ir_write, pc_write, pc_src, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
    //  MemRead, MemWrite, ALUOp[1:0], illegal, mem_timeout}
    localparam logic [13:0] F1   = 14'b1110_0000_0000_00;
    localparam logic [13:0] F0   = 14'b1000_0000_0000_00;
    localparam logic [13:0] RX   = 14'b0000_0000_0010_00;
    localparam logic [13:0] RWB  = 14'b0000_0001_0010_00;
    localparam logic [13:0] AI   = 14'b0000_0100_0010_00;
    localparam logic [13:0] AIWB = 14'b0000_0101_0010_00;
    localparam logic [13:0] CB   = 14'b0000_1000_0001_00;
    localparam logic [13:0] CBT  = 14'b0011_1000_0001_00;
    localparam logic [13:0] CBN  = 14'b0001_1000_0001_00;
    localparam logic [13:0] BD   = 14'b0000_0000_0000_00;
    localparam logic [13:0] BT   = 14'b0011_0000_0000_00;
    localparam logic [13:0] ILP  = 14'b0000_0000_0000_10;
    localparam logic [13:0] ST   = 14'b0000_1100_0000_00;
    localparam logic [13:0] STM  = 14'b0000_1100_0100_00;
    localparam logic [13:0] LDWB = 14'b0000_0111_0000_00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] op = '0;
    logic        instr_valid = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        ir8, iw8, pw8, ps8, r2l8, as8, m2r8, rw8, mr8, mw8, ill8, to8;
    logic [1:0]  aop8;
    logic [31:0] ret8;
    logic        ir4, iw4, pw4, ps4, r2l4, as4, m2r4, rw4, mr4, mw4, ill4, to4;
    logic [1:0]  aop4;
    logic [31:0] ret4;
    logic [13:0] act8, act4;

    assign act8 = {ir8, iw8, pw8, ps8, r2l8, as8, m2r8, rw8, mr8, mw8, aop8, ill8, to8};
    assign act4 = {ir4, iw4, pw4, ps4, r2l4, as4, m2r4, rw4, mr4, mw4, aop4, ill4, to4};

    legv8_mc_ctrl #(.MEM_WAIT_MAX(8), .CNT_W(32)) u_dut8 (
        .clk(clk), .reset(reset), .op(op), .instr_valid(instr_valid), .instr_ready(ir8),
        .zero(zero), .mem_ready(mem_ready), .ir_write(iw8), .pc_write(pw8), .pc_src(ps8),
        .Reg2Loc(r2l8), .ALUSrc(as8), .MemtoReg(m2r8), .RegWrite(rw8), .MemRead(mr8),
        .MemWrite(mw8), .ALUOp(aop8), .illegal(ill8), .mem_timeout(to8), .retired(ret8)
    );

    legv8_mc_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .reset(reset), .op(op), .instr_valid(instr_valid), .instr_ready(ir4),
        .zero(zero), .mem_ready(mem_ready), .ir_write(iw4), .pc_write(pw4), .pc_src(ps4),
        .Reg2Loc(r2l4), .ALUSrc(as4), .MemtoReg(m2r4), .RegWrite(rw4), .MemRead(mr4),
        .MemWrite(mw4), .ALUOp(aop4), .illegal(ill4), .mem_timeout(to4), .retired(ret4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] op;
        logic        iv;
        logic        z;
        logic        mr;
        logic [13:0] exp;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [10:0] o, input logic v, input logic z, input logic m,
                       input logic [13:0] e, input int r);
        tbl.push_back('{o, v, z, m, e, 32'(r)});
    endtask

    task automatic drive(input logic [10:0] o, input logic v, input logic z, input logic m);
        @(posedge clk);
        #1;
        op          = o;
        instr_valid = v;
        zero        = z;
        mem_ready   = m;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mrc, irc, mw8c, mw4c, to8c, to4c, to8cyc, to4cyc;

        add(OP_ADD,  1, 0, 0, F1,   0);
        add(OP_ADD,  0, 0, 0, RX,   0);
        add(OP_ADD,  0, 0, 0, RX,   0);
        add(OP_ADD,  0, 0, 0, RWB,  0);
        add(OP_ADDI, 1, 0, 0, F1,   1);
        add(OP_ADDI, 0, 0, 0, AI,   1);
        add(OP_ADDI, 0, 0, 0, AI,   1);
        add(OP_ADDI, 0, 0, 0, AIWB, 1);
        add(OP_CBZ,  1, 0, 0, F1,   2);
        add(OP_CBZ,  0, 0, 0, CB,   2);
        add(OP_CBZ,  0, 1, 0, CBT,  2);
        add(OP_CBNZ, 1, 1, 0, F1,   3);
        add(OP_CBNZ, 0, 1, 0, CB,   3);
        add(OP_CBNZ, 0, 1, 0, CBN,  3);
        add(OP_B,    1, 0, 0, F1,   4);
        add(OP_B,    0, 1, 0, BD,   4);
        add(OP_B,    0, 0, 0, BT,   4);
        add(OP_ZERO, 1, 0, 0, F1,   5);
        add(OP_ZERO, 0, 0, 0, ILP,  5);
        add(OP_NEAR, 1, 0, 0, F1,   5);
        add(OP_NEAR, 0, 0, 0, ILP,  5);
        add(OP_STUR, 1, 0, 1, F1,   5);
        add(OP_STUR, 0, 0, 1, ST,   5);
        add(OP_STUR, 0, 0, 1, ST,   5);
        add(OP_STUR, 0, 0, 1, STM,  5);
        add(OP_ORR,  1, 0, 1, F1,   6);
        add(OP_ORR,  0, 0, 1, RX,   6);
        add(OP_ORR,  0, 0, 1, RX,   6);
        add(OP_ORR,  0, 0, 1, RWB,  6);
        add(OP_ORR,  0, 0, 0, F0,   7);
        add(OP_CBNZ, 1, 0, 0, F1,   7);
        add(OP_CBNZ, 0, 0, 0, CB,   7);
        add(OP_CBNZ, 0, 0, 0, CBT,  7);
        add(OP_ADD,  0, 0, 0, F0,   8);

        // Reset held with instr_valid high: nothing may leak out.
        reset = 1'b0;
        op = OP_ADD;
        instr_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", 32'(act8), 32'h0);
        check("reset_retired", ret8, 32'd0);
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("release_fetch", 32'(act8), 32'(F0));

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].iv, tbl[i].z, tbl[i].mr);
            check($sformatf("vec%0d_out", i), 32'(act8), 32'(tbl[i].exp));
            check($sformatf("vec%0d_ret", i), ret8, tbl[i].ret);
        end

        // LDUR with mem_ready three cycles late: 4 MEM cycles, 8 cycles total.
        mrc = 0;
        irc = 0;
        for (int c = 1; c <= 9; c++) begin
            drive(OP_LDUR, c == 1, 1'b0, c == 7);
            if (c <= 8) begin
                if (mr8) mrc++;
                if (ir8) irc++;
            end
            if (c == 8) check("ldur_wb", 32'(act8), 32'(LDWB));
            if (c == 9) begin
                check("ldur_back_fetch", 32'(ir8), 32'd1);
                check("ldur_retired", ret8, 32'd9);
            end
        end
        check("ldur_memread_cycles", 32'(mrc), 32'd4);
        check("ldur_ready_once", 32'(irc), 32'd1);

        // STUR with no mem_ready: timeout after exactly MEM_WAIT_MAX MEM cycles.
        mw8c = 0; mw4c = 0; to8c = 0; to4c = 0; to8cyc = 0; to4cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            drive(OP_STUR, c == 1, 1'b0, 1'b0);
            if (mw8) mw8c++;
            if (mw4) mw4c++;
            if (to8) begin to8c++; to8cyc = c; end
            if (to4) begin to4c++; to4cyc = c; end
            if (c == 8)  check("stur4_back_fetch", 32'(ir4), 32'd1);
            if (c == 12) check("stur8_back_fetch", 32'(ir8), 32'd1);
        end
        check("stur4_memwrite_cycles", 32'(mw4c), 32'd4);
        check("stur8_memwrite_cycles", 32'(mw8c), 32'd8);
        check("stur4_timeout_pulses", 32'(to4c), 32'd1);
        check("stur8_timeout_pulses", 32'(to8c), 32'd1);
        check("stur4_timeout_cycle", 32'(to4cyc), 32'd7);
        check("stur8_timeout_cycle", 32'(to8cyc), 32'd11);
        check("stur4_retired", ret4, 32'd9);
        check("stur8_retired", ret8, 32'd9);

        // Reset asserted while LDUR sits in MEM.
        for (int c = 1; c <= 4; c++) drive(OP_LDUR, c == 1, 1'b0, 1'b0);
        check("pre_reset_memread8", 32'(mr8), 32'd1);
        check("pre_reset_memread4", 32'(mr4), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_out8", 32'(act8), 32'h0);
        check("midreset_out4", 32'(act4), 32'h0);
        check("midreset_retired", ret8, 32'd0);
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_hold_out", 32'(act8), 32'h0);
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("post_release_out", 32'(act8), 32'(F0));
        drive(OP_ADD, 1'b1, 1'b0, 1'b0);
        check("post_release_fetch", 32'(act8), 32'(F1));
        check("post_release_retired", ret8, 32'd0);
        drive(OP_ADD, 1'b0, 1'b0, 1'b0);
        check("post_release_decode", 32'(act8), 32'(RX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
